// File: rtl/reg_seq_pkg.sv
// Shared definitions for the register-number sequencer.
// Holds the FSM state encoding and the register number shown outside a run.
package reg_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Register number presented while idle or done.
  localparam int unsigned REGNUM_IDLE = 0;

endpackage

// File: rtl/reg_step.sv
// Next-register computation: +1 or -1 with wrap modulo 2^REG_W.
// Optional feature macro: REG_SEQ_SKIP_ZERO_EN. When it is defined, a step
// that would land on register 0 moves one further in the same direction.
module reg_step #(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] cur,
  input  logic             direction,
  output logic [REG_W-1:0] nxt
);

  logic [REG_W-1:0] raw;

  // Plain +/-1 step, then optionally hop over register 0.
  always_comb begin
    raw = direction ? (cur + REG_W'(1)) : (cur - REG_W'(1));
    nxt = raw;
`ifdef REG_SEQ_SKIP_ZERO_EN
    if (raw == '0) begin
      nxt = direction ? REG_W'(1) : '1;
    end
`endif
  end

endmodule

// File: rtl/reg_sequencer.sv
// Register-number sequencer: after go, walks len steps up or down from base,
// each step gated by ready, then reports done. All outputs are registered.
// Optional feature macro: REG_SEQ_SKIP_ZERO_EN (handled inside reg_step).
module reg_sequencer
  import reg_seq_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int LEN_W = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             go,
  input  logic             direction,
  input  logic [REG_W-1:0] base,
  input  logic [LEN_W-1:0] len,
  input  logic             ready,
  output logic [REG_W-1:0] regnum,
  output logic             valid,
  output logic             done
);

  state_t           state_reg, state_next;
  logic [REG_W-1:0] regnum_reg, regnum_next;
  logic [LEN_W-1:0] cnt_reg, cnt_next;
  logic [REG_W-1:0] base_reg, base_next;
  logic [LEN_W-1:0] len_reg, len_next;
  logic             dir_reg, dir_next;
  logic             valid_reg, done_reg;
  logic [REG_W-1:0] step_value;

  // In START regnum_reg already equals base_reg, so stepping from regnum_reg
  // covers both the first step and every later one.
  reg_step #(.REG_W(REG_W)) u_step (
    .cur       (regnum_reg),
    .direction (dir_reg),
    .nxt       (step_value)
  );

  // Next-state, counter and run-parameter capture.
  always_comb begin
    state_next  = state_reg;
    regnum_next = regnum_reg;
    cnt_next    = cnt_reg;
    base_next   = base_reg;
    len_next    = len_reg;
    dir_next    = dir_reg;

    case (state_reg)
      IDLE, DONE: begin
        regnum_next = REG_W'(REGNUM_IDLE);
        cnt_next    = '0;
        if (go) begin
          state_next  = START;
          base_next   = base;
          len_next    = len;
          dir_next    = direction;
          regnum_next = base;
        end
      end
      START: begin
        if (go) begin
          // Keep tracking the inputs until go drops; they freeze afterwards.
          base_next   = base;
          len_next    = len;
          dir_next    = direction;
          regnum_next = base;
        end else if (len_reg != '0) begin
          state_next  = RUN;
          regnum_next = step_value;
          cnt_next    = LEN_W'(1);
        end else begin
          state_next  = DONE;
          regnum_next = REG_W'(REGNUM_IDLE);
        end
      end
      RUN: begin
        if (ready) begin
          if (cnt_reg == len_reg) begin
            state_next  = DONE;
            regnum_next = REG_W'(REGNUM_IDLE);
            cnt_next    = '0;
          end else begin
            regnum_next = step_value;
            cnt_next    = cnt_reg + LEN_W'(1);
          end
        end
      end
      default: begin
        state_next  = IDLE;
        regnum_next = REG_W'(REGNUM_IDLE);
        cnt_next    = '0;
      end
    endcase
  end

  // State and output registers; valid/done are decoded from the next state
  // so they line up with regnum without a combinational output path.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg  <= IDLE;
      regnum_reg <= '0;
      cnt_reg    <= '0;
      base_reg   <= '0;
      len_reg    <= '0;
      dir_reg    <= 1'b0;
      valid_reg  <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      regnum_reg <= regnum_next;
      cnt_reg    <= cnt_next;
      base_reg   <= base_next;
      len_reg    <= len_next;
      dir_reg    <= dir_next;
      valid_reg  <= (state_next == RUN);
      done_reg   <= (state_next == DONE);
    end
  end

  assign regnum = regnum_reg;
  assign valid  = valid_reg;
  assign done   = done_reg;

endmodule

// File: tb/tb_reg_sequencer.sv
// Directed bench for reg_sequencer: a cycle-by-cycle vector table plus
// hand-written ready-stall and mid-run reset sequences.
module tb_reg_sequencer;

`ifdef REG_SEQ_SKIP_ZERO_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic       clock;
  logic       reset;
  logic       go;
  logic       direction;
  logic [4:0] base;
  logic [2:0] len;
  logic       ready;
  logic [4:0] regnum;
  logic       valid;
  logic       done;

  int n_cmp;
  int n_err;
  int n_txn;

  reg_sequencer #(.REG_W(5), .LEN_W(3)) dut (
    .clock     (clock),
    .reset     (reset),
    .go        (go),
    .direction (direction),
    .base      (base),
    .len       (len),
    .ready     (ready),
    .regnum    (regnum),
    .valid     (valid),
    .done      (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       rst;
    logic       go;
    logic       dir;
    logic [4:0] base;
    logic [2:0] len;
    logic       rdy;
    logic [4:0] e_regnum;
    logic       e_valid;
    logic       e_done;
  } vec_t;

  vec_t vtab[0:63];
  int   nvec;

  task automatic add(input logic r, input logic g, input logic d,
                     input logic [4:0] b, input logic [2:0] l, input logic rd,
                     input logic [4:0] er, input logic ev, input logic ed);
    vtab[nvec].rst      = r;
    vtab[nvec].go       = g;
    vtab[nvec].dir      = d;
    vtab[nvec].base     = b;
    vtab[nvec].len      = l;
    vtab[nvec].rdy      = rd;
    vtab[nvec].e_regnum = er;
    vtab[nvec].e_valid  = ev;
    vtab[nvec].e_done   = ed;
    nvec++;
  endtask

  task automatic check(input string nm, input int idx, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s step %0d: got %0d expected %0d", nm, idx, act, exp);
    end
  endtask

  // Drive one cycle of inputs, clock once, sample 1 ns after the edge.
  task automatic apply(input string tag, input logic r, input logic g, input logic d,
                       input logic [4:0] b, input logic [2:0] l, input logic rd,
                       input logic [4:0] er, input logic ev, input logic ed);
    reset     = r;
    go        = g;
    direction = d;
    base      = b;
    len       = l;
    ready     = rd;
    @(posedge clock);
    #1;
    $display("%s #%0d: rst=%0b go=%0b dir=%0b base=%0d len=%0d rdy=%0b -> regnum=%0d valid=%0b done=%0b",
             tag, n_txn, r, g, d, b, l, rd, regnum, valid, done);
    check({tag, ".regnum"}, n_txn, int'(regnum), int'(er));
    check({tag, ".valid"},  n_txn, int'(valid),  int'(ev));
    check({tag, ".done"},   n_txn, int'(done),   int'(ed));
    n_txn++;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    n_txn = 0;
    nvec  = 0;
    reset = 1'b1; go = 1'b0; direction = 1'b1; base = '0; len = '0; ready = 1'b1;

    //   rst go dir base len rdy | regnum valid done
    // Reset, including reset dominating go.
    add(1, 0, 1, 5'd8,  3'd4, 1,  5'd0,  0, 0);
    add(1, 1, 1, 5'd8,  3'd4, 1,  5'd0,  0, 0);
    add(0, 0, 1, 5'd8,  3'd4, 1,  5'd0,  0, 0);
    // Ascending 8, len 4; inputs and go disturbed mid-run must be ignored.
    add(0, 1, 1, 5'd8,  3'd4, 1,  5'd8,  0, 0);
    add(0, 0, 1, 5'd8,  3'd4, 1,  5'd9,  1, 0);
    add(0, 1, 0, 5'd20, 3'd7, 1,  5'd10, 1, 0);
    add(0, 0, 0, 5'd20, 3'd7, 1,  5'd11, 1, 0);
    add(0, 0, 1, 5'd8,  3'd4, 1,  5'd12, 1, 0);
    add(0, 0, 1, 5'd8,  3'd4, 1,  5'd0,  0, 1);
    add(0, 0, 1, 5'd8,  3'd4, 1,  5'd0,  0, 1);
    // Descending 8, len 4, then go in DONE restarts.
    add(0, 1, 0, 5'd8,  3'd4, 1,  5'd8,  0, 0);
    add(0, 0, 0, 5'd8,  3'd4, 1,  5'd7,  1, 0);
    add(0, 0, 0, 5'd8,  3'd4, 1,  5'd6,  1, 0);
    add(0, 0, 0, 5'd8,  3'd4, 1,  5'd5,  1, 0);
    add(0, 0, 0, 5'd8,  3'd4, 1,  5'd4,  1, 0);
    add(0, 0, 0, 5'd8,  3'd4, 1,  5'd0,  0, 1);
    add(0, 1, 0, 5'd8,  3'd4, 1,  5'd8,  0, 0);
    // Still in START: new inputs are captured; ascending wrap past 31.
    add(0, 1, 1, 5'd30, 3'd3, 1,  5'd30, 0, 0);
    add(0, 0, 1, 5'd30, 3'd3, 1,  5'd31, 1, 0);
    add(0, 0, 1, 5'd30, 3'd3, 1,  SKIP ? 5'd1 : 5'd0, 1, 0);
    add(0, 0, 1, 5'd30, 3'd3, 1,  SKIP ? 5'd2 : 5'd1, 1, 0);
    add(0, 0, 1, 5'd30, 3'd3, 1,  5'd0,  0, 1);
    // len 0: START straight to DONE, valid never high.
    add(0, 1, 1, 5'd5,  3'd0, 1,  5'd5,  0, 0);
    add(0, 0, 1, 5'd5,  3'd0, 1,  5'd0,  0, 1);
    // Descending wrap below 0.
    add(0, 1, 0, 5'd1,  3'd2, 1,  5'd1,  0, 0);
    add(0, 0, 0, 5'd1,  3'd2, 1,  SKIP ? 5'd31 : 5'd0,  1, 0);
    add(0, 0, 0, 5'd1,  3'd2, 1,  SKIP ? 5'd30 : 5'd31, 1, 0);
    add(0, 0, 0, 5'd1,  3'd2, 1,  5'd0,  0, 1);
    // base 0 is shown in START in every build.
    add(0, 1, 1, 5'd0,  3'd1, 1,  5'd0,  0, 0);
    add(0, 0, 1, 5'd0,  3'd1, 1,  5'd1,  1, 0);
    add(0, 0, 1, 5'd0,  3'd1, 1,  5'd0,  0, 1);

    for (int i = 0; i < nvec; i++) begin
      apply("vec", vtab[i].rst, vtab[i].go, vtab[i].dir, vtab[i].base, vtab[i].len,
            vtab[i].rdy, vtab[i].e_regnum, vtab[i].e_valid, vtab[i].e_done);
    end

    // Ready stall: len 2, ready low for two cycles after the first step.
    apply("stall", 0, 1, 1, 5'd8, 3'd2, 1, 5'd8,  0, 0);
    apply("stall", 0, 0, 1, 5'd8, 3'd2, 0, 5'd9,  1, 0);
    apply("stall", 0, 0, 1, 5'd8, 3'd2, 0, 5'd9,  1, 0);
    apply("stall", 0, 0, 1, 5'd8, 3'd2, 0, 5'd9,  1, 0);
    apply("stall", 0, 0, 1, 5'd8, 3'd2, 1, 5'd10, 1, 0);
    apply("stall", 0, 0, 1, 5'd8, 3'd2, 1, 5'd0,  0, 1);

    // Reset on the third RUN step, then a clean run.
    apply("rst", 0, 1, 1, 5'd8, 3'd4, 1, 5'd8,  0, 0);
    apply("rst", 0, 0, 1, 5'd8, 3'd4, 1, 5'd9,  1, 0);
    apply("rst", 0, 0, 1, 5'd8, 3'd4, 1, 5'd10, 1, 0);
    apply("rst", 1, 1, 1, 5'd8, 3'd4, 1, 5'd0,  0, 0);
    apply("rst", 0, 0, 1, 5'd8, 3'd4, 1, 5'd0,  0, 0);
    apply("rst", 0, 1, 1, 5'd8, 3'd4, 1, 5'd8,  0, 0);
    apply("rst", 0, 0, 1, 5'd8, 3'd4, 1, 5'd9,  1, 0);
    apply("rst", 0, 0, 1, 5'd8, 3'd4, 1, 5'd10, 1, 0);
    apply("rst", 0, 0, 1, 5'd8, 3'd4, 1, 5'd11, 1, 0);
    apply("rst", 0, 0, 1, 5'd8, 3'd4, 1, 5'd12, 1, 0);
    apply("rst", 0, 0, 1, 5'd8, 3'd4, 1, 5'd0,  0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
